// File: rtl/miriscv_boot_pkg.sv
// Shared types and constants for the miriscv boot loader.
// BOOT_CHECKSUM_EN adds a trailing XOR checksum byte and a CSUM state.
package miriscv_boot_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, DATA, WRITE, RUN, ERR, CSUM
  } boot_state_e;
`else
  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, DATA, WRITE, RUN, ERR
  } boot_state_e;
`endif

endpackage

// File: rtl/miriscv_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// full_o flags the transfer that completes the current word.
module miriscv_byte_packer
  import miriscv_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (en_i) begin
      // newest byte enters at the top so the first lands in 7:0
      word_d = {data_i, word_q[31:8]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign full_o = en_i &&
    (cnt_q == CW'(BYTES_PER_WORD - 1));
  assign word_o = word_q;

endmodule

// File: rtl/miriscv_boot_loader.sv
// Streams a length-prefixed image into instruction RAM, then releases
// the core. BOOT_CHECKSUM_EN enables a trailing XOR checksum byte.
module miriscv_boot_loader
  import miriscv_boot_pkg::*;
#(
  parameter int RAM_SIZE = 512,
  parameter int ADDR_W   = $clog2(RAM_SIZE)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_n_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int NW = HDR_BYTES * 8;

  boot_state_e   state_q, state_d;
  logic [7:0]    lo_q, lo_d;
  logic [NW-1:0] n_q, n_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic          xfer, pack_en, word_full;
  logic          n_ok, last_word;
  logic [NW-1:0] n_new;
  logic [31:0]   word;

  assign xfer    = byte_valid_i && byte_ready_o;
  assign pack_en = xfer && (state_q == DATA);
  assign n_new   = {byte_data_i, lo_q};
  assign n_ok    = (n_new != '0) &&
                   (32'(n_new) <= RAM_SIZE);
  assign last_word = (32'(idx_q) + 32'd1) >= 32'(n_q);

  miriscv_byte_packer u_packer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (pack_en),
    .data_i (byte_data_i),
    .word_o (word),
    .full_o (word_full)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)        csum_q <= '0;
    else if (pack_en) csum_q <= csum_q ^ byte_data_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= HDR_LO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_LO: if (xfer) state_d = HDR_HI;
      HDR_HI: if (xfer) state_d = n_ok ? DATA : ERR;
      DATA:   if (word_full) state_d = WRITE;
      WRITE: begin
        if (!last_word)  state_d = DATA;
`ifdef BOOT_CHECKSUM_EN
        else             state_d = CSUM;
`else
        else             state_d = RUN;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (xfer)
        state_d = (byte_data_i == csum_q) ? RUN : ERR;
`endif
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // header and word-index registers
  always_comb begin
    lo_d  = lo_q;
    n_d   = n_q;
    idx_d = idx_q;
    if (xfer && state_q == HDR_LO) lo_d = byte_data_i;
    if (xfer && state_q == HDR_HI) n_d  = n_new;
    if (state_q == WRITE && !last_word)
      idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lo_q  <= '0;
      n_q   <= '0;
      idx_q <= '0;
    end else begin
      lo_q  <= lo_d;
      n_q   <= n_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    core_rst_n_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        HDR_LO, HDR_HI, DATA: byte_ready_o = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        CSUM: byte_ready_o = 1'b1;
`endif
        WRITE: begin
          mem_we_o    = 1'b1;
          mem_addr_o  = 32'({idx_q, 2'b00});
          mem_wdata_o = word;
        end
        RUN: begin
          core_rst_n_o = 1'b1;
          done_o       = 1'b1;
        end
        ERR:     err_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_boot_loader.sv
// Self-checking bench for miriscv_boot_loader: stream-level model plus
// directed loads; define BOOT_CHECKSUM_EN to exercise the checksum build.
module tb_miriscv_boot_loader;

  localparam int RS = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic        ready, we, core_n, done, err;
  logic [31:0] addr, wdata;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stim[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  miriscv_boot_loader #(.RAM_SIZE(RS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (valid),
    .byte_data_i  (data),
    .byte_ready_o (ready),
    .mem_we_o     (we),
    .mem_addr_o   (addr),
    .mem_wdata_o  (wdata),
    .core_rst_n_o (core_n),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Stream-level model: what the outputs must be given the bytes
  // accepted so far.
  int          m_k;
  logic [7:0]  m_lo;
  int          m_n;
  logic [31:0] m_acc;
  logic [7:0]  m_cs;
  bit          m_cs_ok;
  bit          m_pend;
  logic [31:0] m_pa, m_pd;

  always @(negedge clk) begin
    bit hdr, bad, ddone, e_done, e_err, e_rdy, nx;
    if (rst) begin
      chk("rst_ready", ready, 0);
      chk("rst_we", we, 0);
      chk("rst_core", core_n, 0);
      chk("rst_done_err", {done, err}, 0);
      m_k = 0; m_n = 0; m_pend = 0;
      m_acc = 0; m_cs = 0; m_cs_ok = 0;
    end else begin
      hdr   = m_k >= 2;
      bad   = hdr && (m_n == 0 || m_n > RS);
      ddone = hdr && !bad && m_k >= 2 + 4 * m_n;
`ifdef BOOT_CHECKSUM_EN
      e_done = ddone && m_k > 2 + 4 * m_n && m_cs_ok;
      e_err  = bad ||
               (ddone && m_k > 2 + 4 * m_n && !m_cs_ok);
`else
      e_done = ddone && !m_pend;
      e_err  = bad;
`endif
      e_rdy = !m_pend && !e_err && !e_done;
      chk("ready", ready, e_rdy);
      chk("we", we, m_pend);
      chk("addr", addr, m_pend ? m_pa : 0);
      chk("wdata", wdata, m_pend ? m_pd : 0);
      chk("core_rst_n", core_n, e_done);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (we) begin
        log_a.push_back(addr);
        log_d.push_back(wdata);
      end
      nx = 0;
      if (valid && e_rdy) begin
        if (m_k == 0) m_lo = data;
        else if (m_k == 1) m_n = {data, m_lo};
        else if (m_k < 2 + 4 * m_n) begin
          m_acc = {data, m_acc[31:8]};
          m_cs  = m_cs ^ data;
          if ((m_k - 2) % 4 == 3) begin
            nx   = 1;
            m_pa = ((m_k - 2) / 4) * 4;
            m_pd = m_acc;
          end
        end else m_cs_ok = (data == m_cs);
        m_k++;
      end
      m_pend = nx;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    valid = 1'b1;
    data  = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk);
        #1;
        valid = 1'b0;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: byte %h never accepted", b);
    valid = 1'b0;
  endtask

  task automatic send_all(input int gap);
    foreach (stim[i]) send(stim[i], gap);
  endtask

  task automatic offer(input logic [7:0] b, input int n);
    valid = 1'b1;
    data  = b;
    idle(n);
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    log_a.delete();
    log_d.delete();
  endtask

  task automatic build(input int n, input logic [31:0] base);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 0;
    stim.delete();
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = base ^ (i * 32'h9E3779B1);
      for (int j = 0; j < 4; j++) begin
        stim.push_back(w[8*j +: 8]);
        cs = cs ^ w[8*j +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(cs);
`endif
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    data = '0;
    idle(3);
    rst = 1'b0;
    log_a.delete();
    log_d.delete();

    stim = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h40, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(8'h52);
`endif
    send_all(0);
    idle(4);
    chk("t1_nwr", log_a.size(), 1);
    if (log_a.size() > 0) begin
      chk("t1_addr", log_a[0], 32'h0);
      chk("t1_data", log_d[0], 32'h00400113);
    end
    chk("t1_done", {core_n, done, err}, 3'b110);

    do_reset();
    build(3, 32'h0A0B0C0D);
    send_all(1);
    idle(4);
    chk("t2_nwr", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("t2_a0", log_a[0], 32'h0);
      chk("t2_a1", log_a[1], 32'h4);
      chk("t2_a2", log_a[2], 32'h8);
      chk("t2_d0", log_d[0], 32'h0A0B0C0D);
    end
    chk("t2_done", done, 1);

    do_reset();
    stim = '{8'h00, 8'h00};
    send_all(0);
    idle(3);
    offer(8'hAA, 4);
    chk("t3a_err", {core_n, done, err}, 3'b001);
    chk("t3a_nwr", log_a.size(), 0);

    do_reset();
    stim = '{8'h01, 8'h02};
    send_all(0);
    idle(3);
    offer(8'h55, 4);
    chk("t3b_err", {core_n, done, err}, 3'b001);
    chk("t3b_nwr", log_a.size(), 0);

    do_reset();
    build(RS, 32'h12345678);
    send_all(0);
    idle(4);
    offer(8'h77, 6);
    chk("t4_nwr", log_a.size(), RS);
    if (log_a.size() > 0)
      chk("t4_last", log_a[log_a.size() - 1], 32'h7FC);
    chk("t4_done", done, 1);

    do_reset();
    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
             8'h44, 8'h55, 8'h66};
    send_all(0);
    do_reset();
    build(1, 32'hDEADBEEF);
    send_all(0);
    idle(4);
    chk("t5_nwr", log_a.size(), 1);
    if (log_a.size() > 0) begin
      chk("t5_addr", log_a[0], 32'h0);
      chk("t5_data", log_d[0], 32'hDEADBEEF);
    end
    chk("t5_done", done, 1);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    stim = '{8'h01, 8'h00, 8'h13, 8'h01, 8'h40,
             8'h00, 8'h53};
    send_all(0);
    idle(4);
    chk("t6_err", {core_n, done, err}, 3'b001);
    chk("t6_nwr", log_a.size(), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
